// File: rtl/hpdcache_l15_req_arbiter.sv
// hpdcache_l15_req_arbiter
// Round-robin arbiter that merges N requester ports onto the single memory
// request channel toward the L1.5. The winner is captured in a one-entry
// output register together with its port index, which the response path
// uses to route the answer back to the issuing port.
//
// Handshake: on every channel a transfer happens at a rising edge where
// valid and ready are both high; the sender keeps valid and payload stable
// until that edge. core_req_ready_o depends combinationally on
// core_req_valid_i and mem_req_ready_i; mem_req_* come straight from flops.

module hpdcache_l15_req_arbiter #(
    parameter int unsigned N            = 2,
    parameter type         req_t        = logic,
    parameter type         req_portid_t = logic
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N-1:0]         core_req_valid_i,
    output logic [N-1:0]         core_req_ready_o,
    input  req_t [N-1:0]         core_req_i,
    output logic                 mem_req_valid_o,
    input  logic                 mem_req_ready_i,
    output req_t                 mem_req_o,
    output req_portid_t          mem_req_portid_o
);

    // Width of the round-robin pointer and of the internal grant index.
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic          out_valid;
    req_t          out_req;
    req_portid_t   out_portid;
    logic [PW-1:0] rr_ptr;

    logic [N-1:0]  grant;
    logic [PW-1:0] grant_idx;
    logic          grant_any;
    logic [PW-1:0] next_ptr;
    logic          load_en;

    // The output register may take a new request when it is empty or
    // its current content leaves this cycle.
    assign load_en = !out_valid || mem_req_ready_i;

    // Search the ports starting at rr_ptr and wrapping; first valid wins.
    always_comb begin
        logic [PW:0] idx_w;
        logic [PW-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx_w     = '0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            idx_w = {1'b0, rr_ptr} + (PW+1)'(i);
            if (idx_w >= (PW+1)'(N)) begin
                idx_w = idx_w - (PW+1)'(N);
            end
            idx = idx_w[PW-1:0];
            if (!grant_any && core_req_valid_i[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_any  = 1'b1;
            end
        end
    end

    // The pointer moves to the port just after the winner, wrapping to 0.
    always_comb begin
        next_ptr = '0;
        if (N > 1 && grant_idx != PW'(N - 1)) begin
            next_ptr = grant_idx + PW'(1);
        end
    end

    // Ready is suppressed during reset so nothing is consumed then.
    assign core_req_ready_o = grant & {N{load_en && !rst_i}};

    // Output stage and round-robin pointer update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid  <= 1'b0;
            out_req    <= '0;
            out_portid <= '0;
            rr_ptr     <= '0;
        end else if (load_en) begin
            if (grant_any) begin
                out_valid  <= 1'b1;
                out_req    <= core_req_i[grant_idx];
                out_portid <= req_portid_t'(grant_idx);
                rr_ptr     <= next_ptr;
            end else begin
                out_valid  <= 1'b0;
            end
        end
    end

    assign mem_req_valid_o  = out_valid;
    assign mem_req_o        = out_req;
    assign mem_req_portid_o = out_portid;

endmodule

// File: tb/tb_hpdcache_l15_req_arbiter.sv
// Bench for hpdcache_l15_req_arbiter with N=4, 8-bit payloads.
// A directed per-cycle vector table covers reset, streaming, stall,
// wrap-around, drain and reset-in-stall; a randomized phase follows,
// checked against a transaction-queue model with a fairness monitor.

module tb_hpdcache_l15_req_arbiter;

    localparam int N = 4;

    // Clock and reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [N-1:0]         core_req_valid_i;
    logic [N-1:0]         core_req_ready_o;
    logic [N-1:0][7:0]    core_req_i;
    logic                 mem_req_valid_o;
    logic                 mem_req_ready_i;
    logic [7:0]           mem_req_o;
    logic [1:0]           mem_req_portid_o;

    hpdcache_l15_req_arbiter #(
        .N            (N),
        .req_t        (logic [7:0]),
        .req_portid_t (logic [1:0])
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .core_req_valid_i (core_req_valid_i),
        .core_req_ready_o (core_req_ready_o),
        .core_req_i       (core_req_i),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_o        (mem_req_o),
        .mem_req_portid_o (mem_req_portid_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Directed vector table: inputs for one cycle plus the values expected
    // during that cycle (ready is combinational, mem_* reflect the prior edge).
    typedef struct {
        logic       r;
        logic [3:0] v;
        logic       mr;
        logic [3:0] exp_ready;
        logic       exp_mv;
        int         exp_port;
        int         exp_src;   // row whose payload is expected on mem_req_o
    } vec_t;

    localparam int NV = 28;
    vec_t vecs[NV];

    task automatic set_vec(input int i, input logic r, input logic [3:0] v, input logic mr,
                           input logic [3:0] er, input logic mv, input int port, input int src);
        vecs[i] = '{r: r, v: v, mr: mr, exp_ready: er, exp_mv: mv, exp_port: port, exp_src: src};
    endtask

    // Payload of port k in table row r
    function automatic logic [7:0] tbl_payload(input int r, input int k);
        return 8'((r << 2) | k);
    endfunction

    // Scoreboard for the random phase: {portid, payload} held in the output stage
    logic [9:0] exp_q[$];
    int         m_ptr;
    int         wait_cnt[N];

    // Round-robin choice from the rules: first valid port scanning from ptr
    function automatic int pick(input logic [3:0] v, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (v[2'((ptr + i) % N)]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic rand_cycle(input logic r);
        int         g;
        logic       can_load;
        logic [3:0] er;
        rst              = r;
        core_req_valid_i = 4'($urandom_range(0, 15));
        mem_req_ready_i  = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < N; k++) core_req_i[k] = 8'($urandom);
        #2;
        g        = pick(core_req_valid_i, m_ptr);
        can_load = (exp_q.size() == 0) || mem_req_ready_i;
        er       = (!r && can_load && g >= 0) ? 4'(1 << g) : 4'b0;
        chk("rnd_ready", 32'(core_req_ready_o), 32'(er));
        chk("rnd_mvalid", 32'(mem_req_valid_o), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("rnd_req", 32'({mem_req_portid_o, mem_req_o}), 32'(exp_q[0]));
        end
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            m_ptr = 0;
            for (int k = 0; k < N; k++) wait_cnt[k] = 0;
        end else if (can_load) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (g >= 0) begin
                exp_q.push_back({2'(g), core_req_i[g]});
                m_ptr = (g + 1) % N;
                for (int k = 0; k < N; k++) begin
                    if (k == g || !core_req_valid_i[k]) begin
                        wait_cnt[k] = 0;
                    end else begin
                        wait_cnt[k]++;
                        chk("rnd_fairness", 32'(wait_cnt[k] <= N - 1), 32'd1);
                    end
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!core_req_valid_i[k]) wait_cnt[k] = 0;
        end
    endtask

    initial begin
        //            row r     v      mr    ready  mv  port src
        set_vec( 0, 1, 4'hF, 1, 4'h0, 0, 0, 0);   // reset hold
        set_vec( 1, 1, 4'hF, 1, 4'h0, 0, 0, 0);
        set_vec( 2, 1, 4'hF, 1, 4'h0, 0, 0, 0);
        set_vec( 3, 0, 4'hF, 1, 4'h1, 0, 0, 0);   // first grant port 0
        set_vec( 4, 0, 4'hF, 1, 4'h2, 1, 0, 3);   // streaming 1,2,3,0,1
        set_vec( 5, 0, 4'hF, 1, 4'h4, 1, 1, 4);
        set_vec( 6, 0, 4'hF, 1, 4'h8, 1, 2, 5);
        set_vec( 7, 0, 4'hF, 1, 4'h1, 1, 3, 6);
        set_vec( 8, 0, 4'hF, 1, 4'h2, 1, 0, 7);
        set_vec( 9, 0, 4'hC, 0, 4'h0, 1, 1, 8);   // stall holding port 1
        set_vec(10, 0, 4'hC, 0, 4'h0, 1, 1, 8);
        set_vec(11, 0, 4'hC, 0, 4'h0, 1, 1, 8);
        set_vec(12, 0, 4'hC, 0, 4'h0, 1, 1, 8);
        set_vec(13, 0, 4'hC, 0, 4'h0, 1, 1, 8);
        set_vec(14, 0, 4'hC, 1, 4'h4, 1, 1, 8);   // retire + accept port 2
        set_vec(15, 0, 4'h8, 1, 4'h8, 1, 2, 14);  // then port 3
        set_vec(16, 0, 4'h5, 1, 4'h1, 1, 3, 15);  // wrap: ptr 0 -> port 0
        set_vec(17, 0, 4'h4, 1, 4'h4, 1, 0, 16);  // then port 2
        set_vec(18, 0, 4'h4, 1, 4'h4, 1, 2, 17);  // ptr 3, only port 2
        set_vec(19, 0, 4'h2, 1, 4'h2, 1, 2, 18);  // single request port 1
        set_vec(20, 0, 4'h0, 1, 4'h0, 1, 1, 19);  // drain
        set_vec(21, 0, 4'h0, 1, 4'h0, 0, 0, 0);
        set_vec(22, 0, 4'h0, 1, 4'h0, 0, 0, 0);
        set_vec(23, 0, 4'hF, 1, 4'h4, 0, 0, 0);   // ptr stayed at 2
        set_vec(24, 0, 4'h0, 0, 4'h0, 1, 2, 23);  // stall with port 2 held
        set_vec(25, 1, 4'h0, 0, 4'h0, 1, 2, 23);  // reset mid-stall
        set_vec(26, 0, 4'hF, 0, 4'h1, 0, 0, 0);   // held request discarded
        set_vec(27, 0, 4'h0, 1, 4'h0, 1, 0, 26);

        // Reset preamble so the first table row sees defined outputs
        rst              = 1'b1;
        core_req_valid_i = '0;
        mem_req_ready_i  = 1'b0;
        core_req_i       = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            rst              = vecs[i].r;
            core_req_valid_i = vecs[i].v;
            mem_req_ready_i  = vecs[i].mr;
            for (int k = 0; k < N; k++) core_req_i[k] = tbl_payload(i, k);
            #2;
            chk($sformatf("row%0d_ready", i), 32'(core_req_ready_o), 32'(vecs[i].exp_ready));
            chk($sformatf("row%0d_mvalid", i), 32'(mem_req_valid_o), 32'(vecs[i].exp_mv));
            if (vecs[i].exp_mv) begin
                chk($sformatf("row%0d_portid", i), 32'(mem_req_portid_o), 32'(vecs[i].exp_port));
                chk($sformatf("row%0d_req", i), 32'(mem_req_o),
                    32'(tbl_payload(vecs[i].exp_src, vecs[i].exp_port)));
            end
            @(posedge clk);
            #1;
        end

        // Randomized phase against the queue model
        rand_cycle(1'b1);
        for (int c = 0; c < 800; c++) begin
            rand_cycle($urandom_range(0, 59) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hpdcache_l15_req_arbiter.md
# hpdcache_l15_req_arbiter

Request-side counterpart of the L1.5 response demultiplexer. It arbitrates N requester ports onto the single memory request channel toward the L1.5 with round-robin fairness, and registers the winner in a one-entry output stage. Alongside each request it emits the winning port index; the response path uses this index as its port-select to route responses back.

## Interface
Parameters:
- `N`, default 2: number of requester ports; legal range N ≥ 1.
- `req_t`, default `logic`: request payload type; it is carried opaquely.
- `req_portid_t`, default `logic`: port index type; `$bits(req_portid_t)` ≥ max(1, $clog2(N)).

Ports:
- `clk_i`, input, 1: clock. All state updates on the rising edge.
- `rst_i`, input, 1: reset. Synchronous and active-high.
- `core_req_valid_i`, input, 1 × [N-1:0]: request valid, one per port.
- `core_req_ready_o`, output, 1 × [N-1:0]: request accepted, one per port.
- `core_req_i`, input, `req_t` × [N-1:0]: request payload, one per port.
- `mem_req_valid_o`, output, 1: registered request valid toward the L1.5.
- `mem_req_ready_i`, input, 1: L1.5 accepts the request.
- `mem_req_o`, output, `req_t`: registered request payload.
- `mem_req_portid_o`, output, `req_portid_t`: index of the port that issued `mem_req_o`.

## Operation
State:
- Output register: `out_valid`, `out_req`, `out_portid`.
- Round-robin pointer `rr_ptr`, in range [0, N-1].

Load enable:
- `load_en = !out_valid || mem_req_ready_i`.

Grant (combinational):
- Search ports in the order `rr_ptr, rr_ptr+1, …, N-1, 0, …, rr_ptr-1`.
- The grant goes to the first port with `core_req_valid_i` set.
- The grant is one-hot, or zero when no port is valid.

Acceptance:
- `core_req_ready_o[k] = load_en && grant[k] && !rst_i`.
- At most one ready bit is high per cycle.
- A ready bit is never high for a port whose valid is low.

On acceptance of port k (clock edge):
- `out_req <= core_req_i[k]`.
- `out_portid <= k`, zero-extended.
- `out_valid <= 1`.
- `rr_ptr <= (k+1) mod N`. The wrap from N-1 goes to 0.

When `load_en` is set and no port is valid:
- `out_valid <= 0`.
- `rr_ptr` is unchanged.

When `load_en` is clear (stall):
- All state holds.
- `mem_req_o` and `mem_req_portid_o` remain stable while `mem_req_valid_o && !mem_req_ready_i`.

Outputs:
- `mem_req_valid_o = out_valid`, `mem_req_o = out_req`, `mem_req_portid_o = out_portid`.

Requester obligation:
- A requester keeps valid and payload stable until it sees ready.
- The arbiter does not check this.

N = 1:
- `rr_ptr` is constant 0 and `mem_req_portid_o` is always 0.
- Behaviour otherwise reduces to a pipeline register.

## Timing
Reset values (`rst_i` high at a clock edge):
- `out_valid = 0` and `rr_ptr = 0`.
- `out_req` and `out_portid` reset to 0.
- While `rst_i` is high, all `core_req_ready_o` are 0, regardless of `mem_req_ready_i`.

Reset mid-operation:
- A request held in the output register is discarded.
- `mem_req_valid_o` is 0 in the cycle after the reset edge.

Latency and throughput:
- Latency is 1 cycle: a request accepted at edge t appears on `mem_req_*` from edge t.
- Throughput is 1 request/cycle. When `out_valid && mem_req_ready_i`, a new request is accepted in the same cycle with no bubble.

Combinational paths:
- `mem_req_ready_i` → `core_req_ready_o`.
- `core_req_valid_i` → `core_req_ready_o`.
- No path from `core_req_valid_i` or `core_req_i` to `mem_req_*`.

Fairness:
- While port k is valid continuously, it is granted within N acceptances.

## Test plan
1. **Reset hold.** N=4, all valid, `mem_req_ready_i=1`, `rst_i` high for 3 cycles → all `core_req_ready_o=0` and `mem_req_valid_o=0`. After release, the first grant is port 0 and `mem_req_portid_o=0` on the next cycle.
2. **Round-robin streaming.** N=4, all valid continuously, `mem_req_ready_i=1` → grants 0,1,2,3,0,1 on consecutive cycles; `mem_req_portid_o` and payload match each port; no idle cycles.
3. **Backpressure.** Output holds the port-1 request and `mem_req_ready_i=0` for 5 cycles with ports 2 and 3 valid → `mem_req_o` and portid stay stable, no `core_req_ready_o`. Raise ready → port-1 request retires, port 2 is accepted in the same cycle, then port 3.
4. **Wrap-around.** Port 3 accepted last (`rr_ptr=0`), then only ports 0 and 2 valid → port 0 granted, then port 2. Repeat with `rr_ptr=3` and only port 2 valid → port 2 granted.
5. **Drain and idle.** Single request from port 1, then no valids, ready=1 → `mem_req_valid_o` high for exactly 1 cycle, then 0; `rr_ptr` stays 2.
6. **Reset mid-stall.** `out_valid=1`, ready=0; assert `rst_i` for 1 cycle → `mem_req_valid_o=0` next cycle, the held request is never presented, and the first grant after release is port 0.
